// File: rtl/updn_sweep_pkg.sv
// Shared state encoding and command mode constants for the up/down sweep sequencer.
package updn_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_UP,
        ST_RUN_DN,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_PP  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

endpackage

// File: rtl/updn_step_counter.sv
// Loadable up/down step counter: load wins over enable, otherwise holds.
module updn_step_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updn_sweep_ctrl.sv
// Command-driven sweep sequencer (up-once / down-once / ping-pong) over a bounded counter.
// Optional UPDN_SWEEP_TURN_IRQ_EN adds a 'turn' pulse after each ping-pong reversal.
module updn_sweep_ctrl
    import updn_sweep_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [WIDTH-1:0]  cmd_lo,
    input  logic [WIDTH-1:0]  cmd_hi,
    input  logic [REPS_W-1:0] cmd_reps,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              cnt_en,
    output logic              cnt_up_down,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef UPDN_SWEEP_TURN_IRQ_EN
    ,
    output logic              turn
`endif
);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [REPS_W-1:0]  rep_left_q, rep_left_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               load, step;
    logic [WIDTH-1:0]   load_val, target;
    logic               accept;

    updn_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (step),
        .up       (state_q == ST_RUN_UP),
        .count    (count)
    );

    assign accept = cmd_valid && cmd_ready;
    assign target = (state_q == ST_RUN_UP) ? hi_q : lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_UP;
            lo_q       <= '0;
            hi_q       <= '0;
            rep_left_q <= '0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            rep_left_q <= rep_left_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        rep_left_d = rep_left_q;
        err_d      = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_lo > cmd_hi || cmd_mode == MODE_RSV) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d     = cmd_mode;
                        lo_d       = cmd_lo;
                        hi_d       = cmd_hi;
                        rep_left_d = (cmd_reps == '0) ? REPS_W'(1) : cmd_reps;
                        load       = 1'b1;
                        if (cmd_mode == MODE_DN) begin
                            load_val = cmd_hi;
                            state_d  = ST_RUN_DN;
                        end else begin
                            load_val = cmd_lo;
                            state_d  = ST_RUN_UP;
                        end
                    end
                end
            end
            ST_RUN_UP, ST_RUN_DN: begin
                // The terminal cycle is a dwell: count holds while the next leg is chosen.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    if (count != target) begin
                        step = 1'b1;
                    end else if (mode_q != MODE_PP) begin
                        state_d = ST_DONE;
                    end else if (state_q == ST_RUN_UP) begin
                        state_d = ST_RUN_DN;
                    end else if (rep_left_q == REPS_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_left_d = rep_left_q - REPS_W'(1);
                        state_d    = ST_RUN_UP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dir_d = dir_q;
        if (state_d == ST_RUN_UP) begin
            dir_d = 1'b1;
        end else if (state_d == ST_RUN_DN) begin
            dir_d = 1'b0;
        end
    end

    always_comb begin
        cmd_ready   = (state_q == ST_IDLE) && !rst;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        cnt_en      = (state_q == ST_RUN_UP || state_q == ST_RUN_DN) && !pause;
        cnt_up_down = dir_q;
        err         = err_q;
    end

`ifdef UPDN_SWEEP_TURN_IRQ_EN
    logic turn_q, turn_d;

    always_comb begin
        turn_d = (state_q == ST_RUN_UP && state_d == ST_RUN_DN) ||
                 (state_q == ST_RUN_DN && state_d == ST_RUN_UP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q <= 1'b0;
        end else begin
            turn_q <= turn_d;
        end
    end

    assign turn = turn_q;
`endif

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Directed self-checking bench for updn_sweep_ctrl; covers turn when UPDN_SWEEP_TURN_IRQ_EN is set.
module tb_updn_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [3:0] cmd_lo = '0;
    logic [3:0] cmd_hi = '0;
    logic [3:0] cmd_reps = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] count;
    logic       cnt_en, cnt_up_down, busy, done, err;
`ifdef UPDN_SWEEP_TURN_IRQ_EN
    logic       turn;
`endif
    logic [5:0] flags;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updn_sweep_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_lo      (cmd_lo),
        .cmd_hi      (cmd_hi),
        .cmd_reps    (cmd_reps),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .cnt_en      (cnt_en),
        .cnt_up_down (cnt_up_down),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef UPDN_SWEEP_TURN_IRQ_EN
        ,
        .turn        (turn)
`endif
    );

    // flags = {cnt_up_down, cnt_en, busy, done, err, cmd_ready}
    assign flags = {cnt_up_down, cnt_en, busy, done, err, cmd_ready};

    // Offer one command in the current cycle; returns at the next negedge (cycle 1).
    task automatic issue(input logic [1:0] m, input logic [3:0] lo, input logic [3:0] hi,
                         input logic [3:0] reps);
        cmd_mode  = m;
        cmd_lo    = lo;
        cmd_hi    = hi;
        cmd_reps  = reps;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=0", cmd_ready);
        end
        n_cmp++;
        if (count !== 4'd0 || flags !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_state got cnt=%0d flags=%b exp cnt=0 flags=100000", count, flags);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_up_once;
        int         ec [7] = '{2, 3, 4, 5, 5, 5, 5};
        logic [5:0] ef;
        issue(2'b00, 4'd2, 4'd5, 4'd0);
        for (int c = 1; c <= 7; c++) begin
            ef = {1'b1, c <= 4, c <= 5, c == 5, 1'b0, c >= 6};
            n_cmp++;
            if (count !== ec[c-1] || flags !== ef) begin
                n_fail++;
                $display("FAIL up_once c=%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                         c, count, flags, ec[c-1], ef);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ping_pong;
        int         ec [14] = '{1, 2, 3, 3, 2, 1, 1, 2, 3, 3, 2, 1, 1, 1};
        logic [5:0] ef;
        logic       ed;
        issue(2'b10, 4'd1, 4'd3, 4'd2);
        for (int c = 1; c <= 14; c++) begin
            ed = (c <= 3) || (c >= 7 && c <= 9);
            ef = {ed, c <= 12, c <= 13, c == 13, 1'b0, c >= 14};
            n_cmp++;
            if (count !== ec[c-1] || flags !== ef) begin
                n_fail++;
                $display("FAIL ping_pong c=%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                         c, count, flags, ec[c-1], ef);
            end
`ifdef UPDN_SWEEP_TURN_IRQ_EN
            n_cmp++;
            if (turn !== (c == 4 || c == 7 || c == 10)) begin
                n_fail++;
                $display("FAIL pp_turn c=%0d got=%b exp=%b", c, turn, (c == 4 || c == 7 || c == 10));
            end
`endif
            // Offer a reserved-mode command while busy: it must be ignored (no err).
            if (c == 1) begin
                cmd_mode  = 2'b11;
                cmd_valid = 1'b1;
            end
            if (c == 12) cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_bad_cmd;
        issue(2'b00, 4'd6, 4'd2, 4'd0);
        n_cmp++;
        if (count !== 4'd1 || flags !== 6'b000011) begin
            n_fail++;
            $display("FAIL bad_lo_hi got cnt=%0d flags=%b exp cnt=1 flags=000011", count, flags);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_lo_hi_pulse got err=%b busy=%b exp err=0 busy=0", err, busy);
        end
        issue(2'b11, 4'd0, 4'd1, 4'd0);
        n_cmp++;
        if (count !== 4'd1 || flags !== 6'b000011) begin
            n_fail++;
            $display("FAIL bad_mode got cnt=%0d flags=%b exp cnt=1 flags=000011", count, flags);
        end
        pause = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (count !== 4'd1 || flags !== 6'b000001) begin
            n_fail++;
            $display("FAIL idle_ctl got cnt=%0d flags=%b exp cnt=1 flags=000001", count, flags);
        end
    endtask

    task automatic test_pause_abort;
        int ec [4] = '{9, 8, 7, 6};
        issue(2'b01, 4'd0, 4'd9, 4'd0);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (count !== ec[c-1] || flags !== 6'b011000) begin
                n_fail++;
                $display("FAIL down c=%0d got cnt=%0d flags=%b exp cnt=%0d flags=011000",
                         c, count, flags, ec[c-1]);
            end
            if (c < 4) @(negedge clk);
        end
        pause = 1'b1;
        #1;
        n_cmp++;
        if (cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_en got=%b exp=0", cnt_en);
        end
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== 4'd6 || flags !== 6'b001000) begin
                n_fail++;
                $display("FAIL paused c=%0d got cnt=%0d flags=%b exp cnt=6 flags=001000",
                         c, count, flags);
            end
        end
        pause = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 4'd5 || flags !== 6'b011000) begin
            n_fail++;
            $display("FAIL resume got cnt=%0d flags=%b exp cnt=5 flags=011000", count, flags);
        end
        @(negedge clk);
        n_cmp++;
        if (count !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_abort got cnt=%0d exp cnt=4", count);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (count !== 4'd4 || flags !== 6'b000001) begin
                n_fail++;
                $display("FAIL aborted k=%0d got cnt=%0d flags=%b exp cnt=4 flags=000001",
                         c, count, flags);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_equal_bounds;
        logic [5:0] ef [3] = '{6'b111000, 6'b101100, 6'b100001};
        issue(2'b00, 4'd7, 4'd7, 4'd0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (count !== 4'd7 || flags !== ef[c-1]) begin
                n_fail++;
                $display("FAIL equal c=%0d got cnt=%0d flags=%b exp cnt=7 flags=%b",
                         c, count, flags, ef[c-1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_short_pp;
        int         ec [6] = '{0, 1, 1, 0, 0, 0};
        logic [5:0] ef;
        int         turns = 0;
        issue(2'b10, 4'd0, 4'd1, 4'd1);
        for (int c = 1; c <= 6; c++) begin
            ef = {c <= 2, c <= 4, c <= 5, c == 5, 1'b0, c >= 6};
            n_cmp++;
            if (count !== ec[c-1] || flags !== ef) begin
                n_fail++;
                $display("FAIL short_pp c=%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                         c, count, flags, ec[c-1], ef);
            end
`ifdef UPDN_SWEEP_TURN_IRQ_EN
            if (turn === 1'b1) turns++;
`endif
            @(negedge clk);
        end
`ifdef UPDN_SWEEP_TURN_IRQ_EN
        n_cmp++;
        if (turns !== 1) begin
            n_fail++;
            $display("FAIL turn_count got=%0d exp=1", turns);
        end
`else
        if (turns != 0) $display("note: unexpected turn count %0d", turns);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset;
        test_up_once;
        test_ping_pong;
        test_bad_cmd;
        test_pause_abort;
        test_equal_bounds;
        test_short_pp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
